// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - stb/ack register bus between the UART bus master and the UART slave
interface uart_bus_master_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;

    modport master (
        output m_adr_o,
        output m_dat_o,
        output m_we_o,
        output m_stb_o,
        input  m_dat_i,
        input  m_ack_i
    );

    modport slave (
        input  m_adr_o,
        input  m_dat_o,
        input  m_we_o,
        input  m_stb_o,
        output m_dat_i,
        output m_ack_i
    );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART register bus initiator: divisor init, TX writes, RX polling into a FIFO
// Optional write-ack timeout with retry: define UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [15:0] DIVISOR       = 16'd54,
    parameter int          POLL_INTERVAL = 16,
    parameter int          RX_DEPTH      = 4,
    parameter int          ACK_TIMEOUT   = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    uart_bus_master_if.master   bus,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                init_done,
    output logic                timeout_err
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

    if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base
        $error("BASE_ADDR must be word aligned");
    end
    if (POLL_INTERVAL < 1 || POLL_INTERVAL > 65535) begin : g_chk_poll
        $error("POLL_INTERVAL out of range");
    end
    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("RX_DEPTH must be a power of two in 2..16");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_chk_timeout
        $error("ACK_TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        S_INIT, S_GAP, S_IDLE, S_TX_WR, S_RX_RD, S_RX_CAP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          init_done_q, init_done_d;
    logic          rr_rx_last_q, rr_rx_last_d;
    logic [15:0]   poll_q, poll_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [RX_DEPTH];
    logic          push, pop, tx_ready_c;
    logic          tx_elig, rx_elig;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;
`endif

    logic unused_dat;
    assign unused_dat = &{1'b0, bus.m_dat_i[31:9]};

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        stb_d        = stb_q;
        init_done_d  = init_done_q;
        rr_rx_last_d = rr_rx_last_q;
        poll_d       = (poll_q != 16'd0) ? poll_q - 16'd1 : 16'd0;
        push         = 1'b0;
        tx_ready_c   = 1'b0;
        tx_elig      = tx_valid;
        rx_elig      = (poll_q == 16'd0) && (count_q != FULL_CNT);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        to_err_d     = to_err_q;
`endif
        case (state_q)
            S_INIT: begin
                if (stb_q && bus.m_ack_i) begin
                    stb_d       = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = S_GAP;
                end else begin
                    adr_d = BASE_ADDR + 32'd1;
                    we_d  = 1'b1;
                    dat_d = {16'b0, DIVISOR};
                    stb_d = 1'b1;
                end
            end
            S_GAP: state_d = S_IDLE;
            S_IDLE: begin
                // Ties go to whichever side was not granted last.
                if (tx_elig && (!rx_elig || rr_rx_last_q)) begin
                    adr_d        = BASE_ADDR;
                    we_d         = 1'b1;
                    dat_d        = {24'b0, tx_data};
                    stb_d        = 1'b1;
                    rr_rx_last_d = 1'b0;
                    state_d      = S_TX_WR;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                    to_cnt_d     = 16'd0;
`endif
                end else if (rx_elig) begin
                    adr_d        = BASE_ADDR;
                    we_d         = 1'b0;
                    dat_d        = 32'd0;
                    stb_d        = 1'b1;
                    rr_rx_last_d = 1'b1;
                    state_d      = S_RX_RD;
                end
            end
            S_TX_WR: begin
                if (bus.m_ack_i) begin
                    tx_ready_c = 1'b1;
                    stb_d      = 1'b0;
                    state_d    = S_GAP;
                end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                else if (to_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
                    stb_d    = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            S_RX_RD: begin
                if (bus.m_ack_i) begin
                    stb_d   = 1'b0;
                    state_d = S_RX_CAP;
                end
            end
            S_RX_CAP: begin
                // A valid byte means more may be waiting, so poll again at once.
                push    = bus.m_dat_i[8];
                poll_d  = bus.m_dat_i[8] ? 16'd0 : 16'(POLL_INTERVAL);
                state_d = S_GAP;
            end
            default: state_d = S_INIT;
        endcase

        pop     = rx_ready && (count_q != '0);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_INIT;
            adr_q        <= BASE_ADDR;
            dat_q        <= 32'd0;
            we_q         <= 1'b0;
            stb_q        <= 1'b0;
            init_done_q  <= 1'b0;
            rr_rx_last_q <= 1'b0;
            poll_q       <= 16'd0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= 8'd0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            to_cnt_q     <= 16'd0;
            to_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            stb_q        <= stb_d;
            init_done_q  <= init_done_d;
            rr_rx_last_q <= rr_rx_last_d;
            poll_q       <= poll_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            if (push) mem_q[wptr_q] <= bus.m_dat_i[7:0];
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            to_err_q     <= to_err_d;
`endif
        end
    end

    assign bus.m_adr_o = adr_q;
    assign bus.m_dat_o = dat_q;
    assign bus.m_we_o  = we_q;
    assign bus.m_stb_o = stb_q;
    assign tx_ready    = tx_ready_c;
    assign rx_data     = mem_q[rptr_q];
    assign rx_valid    = (count_q != '0);
    assign init_done   = init_done_q;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed self-checking bench for uart_bus_master with a behavioural UART slave
module tb_uart_bus_master;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          POLL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       init_done;
    logic       timeout_err;

    uart_bus_master_if bus();

    uart_bus_master #(
        .BASE_ADDR(BASE), .DIVISOR(16'd54), .POLL_INTERVAL(POLL),
        .RX_DEPTH(4), .ACK_TIMEOUT(8)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: reads always ack at once, writes ack while ack_wr_en is set.
    logic        ack_wr_en = 1'b1;
    logic [31:0] rd_q[$];
    assign bus.m_ack_i = bus.m_stb_o & (bus.m_we_o ? ack_wr_en : 1'b1);
    always @(posedge clk) begin
        if (!rst_n) bus.m_dat_i <= 32'd0;
        else if (bus.m_stb_o && bus.m_ack_i && !bus.m_we_o) begin
            if (rd_q.size() != 0) bus.m_dat_i <= rd_q.pop_front();
            else                  bus.m_dat_i <= 32'd0;
        end
    end

    int          n_rd = 0, n_wr = 0, viol = 0;
    logic        p_done = 1'b0, p_stb = 1'b0, p_we = 1'b0;
    logic [31:0] p_adr = 32'd0, p_dat = 32'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_stb_o && p_done) viol++;
            if (bus.m_stb_o && p_stb && !p_done &&
                (bus.m_adr_o != p_adr || bus.m_we_o != p_we || bus.m_dat_o != p_dat)) viol++;
            if (bus.m_stb_o && bus.m_ack_i) begin
                if (bus.m_we_o) n_wr++;
                else            n_rd++;
            end
        end
        p_done = bus.m_stb_o && bus.m_ack_i;
        p_stb  = bus.m_stb_o;
        p_we   = bus.m_we_o;
        p_adr  = bus.m_adr_o;
        p_dat  = bus.m_dat_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 read, 1 write, 2 any. Returns at the negedge of the ack cycle.
    task automatic wait_ack(input int kind, input string tag, output int t);
        logic found = 1'b0;
        t = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.m_stb_o && bus.m_ack_i && (kind == 2 || int'(bus.m_we_o) == kind)) begin
                found = 1'b1;
                t = cyc;
            end
        end
        check({tag, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (tx_ready) found = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, t1, r0, r1, hi, rise;
        logic prev, any_ready, found;
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_stb",   {31'd0, bus.m_stb_o}, 32'd0);
        check("rst_adr",   bus.m_adr_o, BASE);
        check("rst_we",    {31'd0, bus.m_we_o}, 32'd0);
        check("rst_dat",   bus.m_dat_o, 32'd0);
        check("rst_flags", {28'd0, init_done, tx_ready, rx_valid, timeout_err}, 32'd0);

        @(posedge clk); #1 rst_n = 1'b1;

        wait_ack(2, "init", t0);
        check("init_we",    {31'd0, bus.m_we_o}, 32'd1);
        check("init_adr",   bus.m_adr_o, BASE + 32'd1);
        check("init_dat",   bus.m_dat_o, 32'h36);
        check("init_done0", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        check("init_stb_low", {31'd0, bus.m_stb_o}, 32'd0);
        check("init_done1",   {31'd0, init_done}, 32'd1);

        @(posedge clk); #1 tx_data = 8'h41; tx_valid = 1'b1;
        wait_ready("tx");
        check("tx_adr", bus.m_adr_o, BASE);
        check("tx_dat", bus.m_dat_o, 32'h41);
        check("tx_we",  {31'd0, bus.m_we_o}, 32'd1);
        @(posedge clk); #1 tx_valid = 1'b0;
        @(negedge clk);
        check("tx_ready_pulse", {31'd0, tx_ready}, 32'd0);
        check("tx_stb_gap",     {31'd0, bus.m_stb_o}, 32'd0);

        @(posedge clk); #1 rd_q.push_back(32'h155);
        wait_ack(0, "rx", t0);
        @(negedge clk);
        check("rx_valid_cap", {31'd0, rx_valid}, 32'd0);
        @(negedge clk);
        check("rx_valid", {31'd0, rx_valid}, 32'd1);
        check("rx_data",  {24'd0, rx_data}, 32'h55);
        @(negedge clk);
        check("rx_gap_low", {31'd0, bus.m_stb_o}, 32'd0);
        @(negedge clk);
        check("rx_poll_immediate", {31'd0, bus.m_stb_o && !bus.m_we_o}, 32'd1);
        t1    = cyc;
        prev  = 1'b1;
        found = 1'b0;
        rise  = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.m_stb_o && !prev) begin
                found = 1'b1;
                rise  = cyc;
            end
            prev = bus.m_stb_o;
        end
        check("poll_interval", rise - t1, POLL + 3);

        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        check("rx_pop_empty", {31'd0, rx_valid}, 32'd0);

        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) rd_q.push_back(32'h100 + i);
        r0 = n_rd;
        repeat (120) @(posedge clk);
        #1;
        check("full_left",  rd_q.size(), 32'd1);
        check("full_reads", n_rd - r0, 32'd4);
        check("full_head",  {23'd0, rx_valid, rx_data}, 32'h101);
        r1 = n_rd;
        repeat (40) @(posedge clk);
        #1 check("full_no_poll", n_rd - r1, 32'd0);
        rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("full_one_poll", n_rd - r1, 32'd1);
        check("full_left0",    rd_q.size(), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            check("drain_data", {23'd0, rx_valid, rx_data}, 32'h100 + i);
            @(posedge clk); #1 rx_ready = 1'b1;
            @(posedge clk); #1 rx_ready = 1'b0;
        end
        @(negedge clk);
        check("drain_empty", {31'd0, rx_valid}, 32'd0);

        @(posedge clk); #1;
        rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) rd_q.push_back(32'h1B0 + i);
        tx_data  = 8'h61;
        tx_valid = 1'b1;
        wait_ack(0, "rr_first", t0);
        for (int i = 0; i < 6; i++) begin
            wait_ack(2, "rr", t0);
            check("rr_we", {31'd0, bus.m_we_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wait_ready("rr_tx");
        check("rr_tx_dat", bus.m_dat_o, 32'h61);
        @(posedge clk); #1 tx_data = 8'h77;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        wait_ack(0, "to_pre_rd", t0);
        ack_wr_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.m_stb_o && bus.m_we_o) found = 1'b1;
        end
        check("to_wr_seen", {31'd0, found}, 32'd1);
        check("to_wr_dat",  bus.m_dat_o, 32'h77);
        hi        = 1;
        any_ready = tx_ready;
        found     = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.m_stb_o) begin
                hi++;
                any_ready = any_ready | tx_ready;
            end else found = 1'b1;
        end
        check("to_stb_cycles", hi, 32'd8);
        check("to_err",        {31'd0, timeout_err}, 32'd1);
        check("to_no_ready",   {31'd0, any_ready}, 32'd0);
        wait_ack(2, "to_next", t0);
        check("to_rx_first", {31'd0, bus.m_we_o}, 32'd0);
        ack_wr_en = 1'b1;
        wait_ack(2, "to_retry", t0);
        check("to_retry_we",  {31'd0, bus.m_we_o}, 32'd1);
        check("to_retry_dat", bus.m_dat_o, 32'h77);
        check("to_retry_rdy", {31'd0, tx_ready}, 32'd1);
        @(posedge clk); #1 tx_valid = 1'b0;
`else
        wait_ready("tx2");
        check("tx2_dat", bus.m_dat_o, 32'h77);
        @(posedge clk); #1 tx_valid = 1'b0;
        check("no_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

        repeat (100) @(posedge clk);
        #1;
        check("rd_q_drained", rd_q.size(), 32'd0);
        check("bus_protocol", viol, 32'd0);
        check("wr_count_min", {31'd0, n_wr >= 4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
